// File: rtl/atm_cliente_seq.sv
`default_nettype none
// ============================================================================
// Module   : atm_cliente_seq
// Purpose  : Synthesizable user-side initiator for the ATM controller. On a
//            host start it inserts the card, keys a 4-digit BCD PIN (retrying
//            on pin_incorrecto), strobes the amount and collects the
//            controller's response, then reports it with a one-cycle done.
// Ports    :
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   start                    host request, sampled only in IDLE
//   pin_in[15:0]             four BCD digits, [15:12] keyed first
//   tipo_in                  0 = deposit, 1 = withdrawal
//   monto_in[31:0]           transaction amount
//   tarjeta_recibida         card present (level)
//   tipo_trans               latched transaction type
//   add_digit                PIN entry window of the current attempt
//   digito_stb, digito[3:0]  one-cycle digit strobe and its value
//   monto_stb, monto[31:0]   one-cycle amount strobe and latched amount
//   balance_actualizado, entregar_dinero, pin_incorrecto, advertencia,
//   bloqueo, fondos_insuficientes   controller responses
//   busy                     transaction in progress
//   done                     one-cycle completion pulse
//   resultado[2:0]           0 dep OK, 1 wd OK, 2 no funds, 3 blocked, 4 timeout
//   intentos[1:0]            PIN attempts used
//   vio_advertencia          advertencia seen during this transaction (sticky)
// Revision : 1.0 - initial release
// ============================================================================
module atm_cliente_seq #(
   parameter int DIG_GAP      = 2,
   parameter int PIN_WAIT     = 4,
   parameter int TIMEOUT      = 64,
   parameter int MAX_INTENTOS = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] pin_in,
   input  logic        tipo_in,
   input  logic [31:0] monto_in,
   output logic        tarjeta_recibida,
   output logic        tipo_trans,
   output logic        add_digit,
   output logic        digito_stb,
   output logic [3:0]  digito,
   output logic        monto_stb,
   output logic [31:0] monto,
   input  logic        balance_actualizado,
   input  logic        entregar_dinero,
   input  logic        pin_incorrecto,
   input  logic        advertencia,
   input  logic        bloqueo,
   input  logic        fondos_insuficientes,
   output logic        busy,
   output logic        done,
   output logic [2:0]  resultado,
   output logic [1:0]  intentos,
   output logic        vio_advertencia
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CARD     = 3'd1,
      ST_PIN      = 3'd2,
      ST_WAIT_PIN = 3'd3,
      ST_MONTO    = 3'd4,
      ST_WAIT_RES = 3'd5,
      ST_DONE     = 3'd6
   } state_t;

   // One shared counter serves the digit gap, the PIN acceptance window and
   // the response timeout; size it for the largest of them.
   localparam int CNT_W = $clog2(TIMEOUT + PIN_WAIT + DIG_GAP + 2);

   localparam logic [CNT_W-1:0] c_dig_gap  = CNT_W'(DIG_GAP);
   localparam logic [CNT_W-1:0] c_pin_last = CNT_W'(PIN_WAIT - 1);
   localparam logic [CNT_W-1:0] c_timeout  = CNT_W'(TIMEOUT);
   localparam logic [1:0]       c_max_int  = 2'(MAX_INTENTOS);

   localparam logic [2:0] c_res_dep_ok   = 3'd0;
   localparam logic [2:0] c_res_wd_ok    = 3'd1;
   localparam logic [2:0] c_res_no_funds = 3'd2;
   localparam logic [2:0] c_res_blocked  = 3'd3;
   localparam logic [2:0] c_res_timeout  = 3'd4;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        idx_q, idx_d;
   logic [15:0]       pin_q, pin_d;
   logic              tarjeta_q, tarjeta_d;
   logic              tipo_q, tipo_d;
   logic              add_digit_q, add_digit_d;
   logic              digito_stb_q, digito_stb_d;
   logic [3:0]        digito_q, digito_d;
   logic              monto_stb_q, monto_stb_d;
   logic [31:0]       monto_q, monto_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [2:0]        resultado_q, resultado_d;
   logic [1:0]        intentos_q, intentos_d;
   logic              vio_q, vio_d;

   logic [CNT_W-1:0]  w_cnt_inc;
   logic [3:0]        w_next_digit;
   logic              w_pin_start;
   logic              w_finish;
   logic [2:0]        w_res;

   assign w_cnt_inc = cnt_q + 1'b1;

   // Digit following the one at idx_q; index 3 never reaches here.
   always_comb begin
      w_next_digit = pin_q[3:0];
      case (idx_q)
         2'd0:    w_next_digit = pin_q[11:8];
         2'd1:    w_next_digit = pin_q[7:4];
         default: w_next_digit = pin_q[3:0];
      endcase
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      pin_d        = pin_q;
      tarjeta_d    = tarjeta_q;
      tipo_d       = tipo_q;
      add_digit_d  = add_digit_q;
      digito_stb_d = 1'b0;
      digito_d     = 4'd0;
      monto_stb_d  = 1'b0;
      monto_d      = monto_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      resultado_d  = resultado_q;
      intentos_d   = intentos_q;
      vio_d        = vio_q | ((state_q != ST_IDLE) & advertencia);
      w_pin_start  = 1'b0;
      w_finish     = 1'b0;
      w_res        = resultado_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d     = ST_CARD;
               pin_d       = pin_in;
               tipo_d      = tipo_in;
               monto_d     = monto_in;
               tarjeta_d   = 1'b1;
               busy_d      = 1'b1;
               intentos_d  = 2'd0;
               resultado_d = 3'd0;
               vio_d       = 1'b0;
               cnt_d       = '0;
            end
         end

         ST_CARD: w_pin_start = 1'b1;

         ST_PIN: begin
            // cnt_q is 0 on a strobe cycle and k on the k-th gap cycle, so
            // the next strobe is due once cnt_q has reached DIG_GAP.
            if (digito_stb_q && (idx_q == 2'd3)) begin
               state_d     = ST_WAIT_PIN;
               add_digit_d = 1'b0;
               cnt_d       = '0;
            end else if (cnt_q == c_dig_gap) begin
               digito_stb_d = 1'b1;
               digito_d     = w_next_digit;
               idx_d        = idx_q + 2'd1;
               cnt_d        = '0;
            end else begin
               cnt_d = w_cnt_inc;
            end
         end

         ST_WAIT_PIN: begin
            if (bloqueo) begin
               w_finish = 1'b1;
               w_res    = c_res_blocked;
            end else if (pin_incorrecto) begin
               if (intentos_q < c_max_int) begin
                  w_pin_start = 1'b1;
               end else begin
                  w_finish = 1'b1;
                  w_res    = c_res_blocked;
               end
            end else if (cnt_q == c_pin_last) begin
               state_d     = ST_MONTO;
               monto_stb_d = 1'b1;
               cnt_d       = '0;
            end else begin
               cnt_d = w_cnt_inc;
            end
         end

         ST_MONTO: begin
            // Counter is 0 on the strobe cycle, so it equals cycles elapsed
            // since monto_stb while waiting for the result.
            state_d = ST_WAIT_RES;
            cnt_d   = w_cnt_inc;
         end

         ST_WAIT_RES: begin
            if (bloqueo) begin
               w_finish = 1'b1;
               w_res    = c_res_blocked;
            end else if (!tipo_q && balance_actualizado) begin
               w_finish = 1'b1;
               w_res    = c_res_dep_ok;
            end else if (tipo_q && fondos_insuficientes) begin
               w_finish = 1'b1;
               w_res    = c_res_no_funds;
            end else if (tipo_q && entregar_dinero) begin
               w_finish = 1'b1;
               w_res    = c_res_wd_ok;
            end else if (w_cnt_inc == c_timeout) begin
               // done lands exactly TIMEOUT cycles after monto_stb
               w_finish = 1'b1;
               w_res    = c_res_timeout;
            end else begin
               cnt_d = w_cnt_inc;
            end
         end

         ST_DONE: begin
            state_d   = ST_IDLE;
            tarjeta_d = 1'b0;
            tipo_d    = 1'b0;
            busy_d    = 1'b0;
            monto_d   = 32'd0;
            cnt_d     = '0;
         end

         default: state_d = ST_IDLE;
      endcase

      // Every attempt restarts from the first digit with the latched PIN.
      if (w_pin_start) begin
         state_d      = ST_PIN;
         add_digit_d  = 1'b1;
         digito_stb_d = 1'b1;
         digito_d     = pin_q[15:12];
         idx_d        = 2'd0;
         cnt_d        = '0;
         intentos_d   = intentos_q + 2'd1;
      end

      if (w_finish) begin
         state_d     = ST_DONE;
         done_d      = 1'b1;
         resultado_d = w_res;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         idx_q        <= 2'd0;
         pin_q        <= 16'd0;
         tarjeta_q    <= 1'b0;
         tipo_q       <= 1'b0;
         add_digit_q  <= 1'b0;
         digito_stb_q <= 1'b0;
         digito_q     <= 4'd0;
         monto_stb_q  <= 1'b0;
         monto_q      <= 32'd0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         resultado_q  <= 3'd0;
         intentos_q   <= 2'd0;
         vio_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         pin_q        <= pin_d;
         tarjeta_q    <= tarjeta_d;
         tipo_q       <= tipo_d;
         add_digit_q  <= add_digit_d;
         digito_stb_q <= digito_stb_d;
         digito_q     <= digito_d;
         monto_stb_q  <= monto_stb_d;
         monto_q      <= monto_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         resultado_q  <= resultado_d;
         intentos_q   <= intentos_d;
         vio_q        <= vio_d;
      end
   end

   assign tarjeta_recibida = tarjeta_q;
   assign tipo_trans       = tipo_q;
   assign add_digit        = add_digit_q;
   assign digito_stb       = digito_stb_q;
   assign digito           = digito_q;
   assign monto_stb        = monto_stb_q;
   assign monto            = monto_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign resultado        = resultado_q;
   assign intentos         = intentos_q;
   assign vio_advertencia  = vio_q;

endmodule
`default_nettype wire

// File: tb/tb_atm_cliente_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_atm_cliente_seq
// Purpose  : Directed self-checking bench for atm_cliente_seq. Plays the ATM
//            controller by hand, records strobes/done in a negedge monitor and
//            compares against hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_atm_cliente_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] pin_in;
   logic        tipo_in;
   logic [31:0] monto_in;
   logic        tarjeta_recibida, tipo_trans, add_digit, digito_stb;
   logic [3:0]  digito;
   logic        monto_stb;
   logic [31:0] monto;
   logic        balance_actualizado, entregar_dinero, pin_incorrecto;
   logic        advertencia, bloqueo, fondos_insuficientes;
   logic        busy, done;
   logic [2:0]  resultado;
   logic [1:0]  intentos;
   logic        vio_advertencia;

   int tests = 0;
   int fails = 0;

   atm_cliente_seq #(
      .DIG_GAP(2), .PIN_WAIT(4), .TIMEOUT(64), .MAX_INTENTOS(3)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .pin_in(pin_in), .tipo_in(tipo_in),
      .monto_in(monto_in), .tarjeta_recibida(tarjeta_recibida),
      .tipo_trans(tipo_trans), .add_digit(add_digit), .digito_stb(digito_stb),
      .digito(digito), .monto_stb(monto_stb), .monto(monto),
      .balance_actualizado(balance_actualizado), .entregar_dinero(entregar_dinero),
      .pin_incorrecto(pin_incorrecto), .advertencia(advertencia), .bloqueo(bloqueo),
      .fondos_insuficientes(fondos_insuficientes), .busy(busy), .done(done),
      .resultado(resultado), .intentos(intentos), .vio_advertencia(vio_advertencia)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Negedge monitor: event log with cycle stamps.
   int          cyc = 0;
   int          n_dig = 0;
   int          dig_val [256];
   int          dig_cyc [256];
   int          n_monto = 0;
   int          monto_cyc = 0;
   logic [31:0] monto_seen = 32'd0;
   logic        tipo_at_monto = 1'b0;
   logic        card_at_monto = 1'b0;
   int          n_done = 0;
   int          done_cyc = 0;
   logic [2:0]  done_res = 3'd0;
   logic [1:0]  done_int = 2'd0;
   logic        done_vio = 1'b0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (digito_stb === 1'b1 && n_dig < 256) begin
         dig_val[n_dig] <= int'(digito);
         dig_cyc[n_dig] <= cyc;
         n_dig          <= n_dig + 1;
      end
      if (monto_stb === 1'b1) begin
         n_monto       <= n_monto + 1;
         monto_cyc     <= cyc;
         monto_seen    <= monto;
         tipo_at_monto <= tipo_trans;
         card_at_monto <= tarjeta_recibida;
      end
      if (done === 1'b1) begin
         n_done   <= n_done + 1;
         done_cyc <= cyc;
         done_res <= resultado;
         done_int <= intentos;
         done_vio <= vio_advertencia;
      end
   end

   // ---------------- stimulus helpers (no checking inside) ----------------
   task automatic do_start(input logic [15:0] p, input logic t, input logic [31:0] m);
      @(negedge clk);
      pin_in = p; tipo_in = t; monto_in = m; start = 1'b1;
      @(negedge clk);
      start = 1'b0; pin_in = ~p; tipo_in = ~t; monto_in = ~m;
   endtask

   // Counts strobes including the current negedge, returns on the k-th.
   task automatic wait_digits(input int k, output bit ok);
      int seen = 0;
      ok = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (digito_stb === 1'b1) begin
            seen++;
            if (seen == k) begin ok = 1'b1; break; end
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_monto(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (monto_stb === 1'b1) begin ok = 1'b1; break; end
         @(negedge clk);
      end
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (done === 1'b1) begin ok = 1'b1; break; end
         @(negedge clk);
      end
   endtask

   // ------------------------------- tests ----------------------------------
   task automatic test_reset();
      rst = 1'b1; start = 1'b0; pin_in = 16'd0; tipo_in = 1'b0; monto_in = 32'd0;
      balance_actualizado = 1'b0; entregar_dinero = 1'b0; pin_incorrecto = 1'b0;
      advertencia = 1'b0; bloqueo = 1'b0; fondos_insuficientes = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if ({tarjeta_recibida, tipo_trans, add_digit, digito_stb, digito, monto_stb, monto,
           busy, done, resultado, intentos, vio_advertencia} !== 50'd0) begin
         fails++; $display("FAIL reset_outputs: got busy=%b tarj=%b res=%0d int=%0d monto=%0h want all 0",
                           busy, tarjeta_recibida, resultado, intentos, monto);
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         fails++; $display("FAIL reset_idle_hold: got busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   task automatic test_deposit();
      int b_dig, b_mon; bit ok;
      b_dig = n_dig; b_mon = n_monto;
      do_start(16'h1234, 1'b0, 32'd500);
      wait_monto(ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL dep_monto_wait: got no monto_stb want one"); end
      repeat (3) @(negedge clk);
      balance_actualizado = 1'b1;
      @(negedge clk);
      balance_actualizado = 1'b0;
      wait_done(ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL dep_done_wait: got no done want done"); end
      @(negedge clk);
      tests++;
      if (n_dig - b_dig !== 4) begin
         fails++; $display("FAIL dep_digit_count: got %0d want 4", n_dig - b_dig);
      end
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (dig_val[b_dig + i] !== i + 1) begin
            fails++; $display("FAIL dep_digit_%0d: got %0d want %0d", i, dig_val[b_dig + i], i + 1);
         end
      end
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (dig_cyc[b_dig + i + 1] - dig_cyc[b_dig + i] !== 3) begin
            fails++; $display("FAIL dep_digit_gap_%0d: got %0d want 3", i,
                              dig_cyc[b_dig + i + 1] - dig_cyc[b_dig + i]);
         end
      end
      tests++;
      if (monto_cyc - dig_cyc[b_dig + 3] !== 5) begin
         fails++; $display("FAIL dep_pin_wait: got %0d want 5", monto_cyc - dig_cyc[b_dig + 3]);
      end
      tests++;
      if (n_monto - b_mon !== 1 || monto_seen !== 32'd500 || card_at_monto !== 1'b1) begin
         fails++; $display("FAIL dep_monto: got n=%0d monto=%0d card=%b want 1 500 1",
                           n_monto - b_mon, monto_seen, card_at_monto);
      end
      tests++;
      if (done_res !== 3'd0 || done_int !== 2'd1 || done_vio !== 1'b0) begin
         fails++; $display("FAIL dep_result: got res=%0d int=%0d vio=%b want 0 1 0",
                           done_res, done_int, done_vio);
      end
      tests++;
      if (busy !== 1'b0 || tarjeta_recibida !== 1'b0 || resultado !== 3'd0 || intentos !== 2'd1) begin
         fails++; $display("FAIL dep_after_done: got busy=%b tarj=%b res=%0d int=%0d want 0 0 0 1",
                           busy, tarjeta_recibida, resultado, intentos);
      end
   endtask

   task automatic test_insufficient();
      bit ok;
      do_start(16'h0001, 1'b1, 32'hFFFF_FFFF);
      wait_monto(ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL nof_monto_wait: got no monto_stb want one"); end
      @(negedge clk);
      fondos_insuficientes = 1'b1; entregar_dinero = 1'b1;
      @(negedge clk);
      fondos_insuficientes = 1'b0; entregar_dinero = 1'b0;
      wait_done(ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL nof_done_wait: got no done want done"); end
      @(negedge clk);
      tests++;
      if (monto_seen !== 32'hFFFF_FFFF || tipo_at_monto !== 1'b1) begin
         fails++; $display("FAIL nof_latch: got monto=%h tipo=%b want ffffffff 1", monto_seen, tipo_at_monto);
      end
      tests++;
      if (done_res !== 3'd2 || done_int !== 2'd1) begin
         fails++; $display("FAIL nof_result: got res=%0d int=%0d want 2 1", done_res, done_int);
      end
   endtask

   task automatic test_bad_pin_once();
      int b_dig; bit ok; int exp_d; logic [15:0] p;
      p = 16'h9870;
      b_dig = n_dig;
      do_start(p, 1'b1, 32'd100);
      wait_digits(4, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL bad1_first_attempt: got timeout want 4 strobes"); end
      repeat (2) @(negedge clk);
      pin_incorrecto = 1'b1; advertencia = 1'b1;
      @(negedge clk);
      pin_incorrecto = 1'b0; advertencia = 1'b0;
      wait_monto(ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL bad1_monto_wait: got no monto_stb want one"); end
      @(negedge clk);
      @(negedge clk);
      entregar_dinero = 1'b1;
      @(negedge clk);
      entregar_dinero = 1'b0;
      wait_done(ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL bad1_done_wait: got no done want done"); end
      @(negedge clk);
      tests++;
      if (n_dig - b_dig !== 8) begin
         fails++; $display("FAIL bad1_digit_count: got %0d want 8", n_dig - b_dig);
      end
      for (int i = 0; i < 8; i++) begin
         exp_d = int'((p >> (12 - 4 * (i % 4))) & 16'h000F);
         tests++;
         if (dig_val[b_dig + i] !== exp_d) begin
            fails++; $display("FAIL bad1_digit_%0d: got %0d want %0d", i, dig_val[b_dig + i], exp_d);
         end
      end
      tests++;
      if (done_res !== 3'd1 || done_int !== 2'd2 || done_vio !== 1'b1) begin
         fails++; $display("FAIL bad1_result: got res=%0d int=%0d vio=%b want 1 2 1",
                           done_res, done_int, done_vio);
      end
      tests++;
      if (vio_advertencia !== 1'b1) begin
         fails++; $display("FAIL bad1_vio_sticky: got %b want 1", vio_advertencia);
      end
   endtask

   task automatic test_three_bad();
      int b_dig, b_mon; bit ok;
      b_dig = n_dig; b_mon = n_monto;
      do_start(16'h2580, 1'b0, 32'd42);
      for (int a = 0; a < 3; a++) begin
         wait_digits(4, ok);
         tests++;
         if (!ok) begin fails++; $display("FAIL bad3_attempt_%0d: got timeout want 4 strobes", a); end
         repeat (2) @(negedge clk);
         pin_incorrecto = 1'b1;
         @(negedge clk);
         pin_incorrecto = 1'b0;
      end
      wait_done(ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL bad3_done_wait: got no done want done"); end
      @(negedge clk);
      tests++;
      if (n_dig - b_dig !== 12 || n_monto - b_mon !== 0) begin
         fails++; $display("FAIL bad3_counts: got dig=%0d monto=%0d want 12 0",
                           n_dig - b_dig, n_monto - b_mon);
      end
      tests++;
      if (done_res !== 3'd3 || done_int !== 2'd3 || done_vio !== 1'b0) begin
         fails++; $display("FAIL bad3_result: got res=%0d int=%0d vio=%b want 3 3 0",
                           done_res, done_int, done_vio);
      end
   endtask

   task automatic test_timeout();
      bit ok;
      do_start(16'h1111, 1'b0, 32'd7);
      wait_monto(ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL tmo_monto_wait: got no monto_stb want one"); end
      wait_done(ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL tmo_done_wait: got no done want done"); end
      @(negedge clk);
      tests++;
      if (done_cyc - monto_cyc !== 64 || done_res !== 3'd4) begin
         fails++; $display("FAIL tmo_latency: got %0d cycles res=%0d want 64 4",
                           done_cyc - monto_cyc, done_res);
      end
   endtask

   task automatic test_busy_start_and_reset();
      int b_dig, b_done; bit ok;
      b_done = n_done;
      do_start(16'h5678, 1'b1, 32'd9);
      wait_digits(1, ok);
      // start while busy must be ignored
      start = 1'b1; pin_in = 16'h1111;
      @(negedge clk);
      start = 1'b0;
      wait_digits(1, ok);
      tests++;
      if (!ok || digito !== 4'd6 || intentos !== 2'd1) begin
         fails++; $display("FAIL busy_start_ignored: got ok=%b digit=%0d int=%0d want 1 6 1",
                           ok, digito, intentos);
      end
      rst = 1'b1;
      @(negedge clk);
      tests++;
      if ({tarjeta_recibida, tipo_trans, add_digit, digito_stb, digito, monto_stb, monto,
           busy, done, resultado, intentos, vio_advertencia} !== 50'd0) begin
         fails++; $display("FAIL abort_outputs: got busy=%b tarj=%b tipo=%b add=%b int=%0d want all 0",
                           busy, tarjeta_recibida, tipo_trans, add_digit, intentos);
      end
      rst = 1'b0;
      repeat (20) @(negedge clk);
      tests++;
      if (n_done !== b_done || busy !== 1'b0) begin
         fails++; $display("FAIL abort_no_done: got dones=%0d busy=%b want 0 0", n_done - b_done, busy);
      end
      b_dig = n_dig;
      do_start(16'h4321, 1'b0, 32'd77);
      wait_monto(ok);
      @(negedge clk);
      balance_actualizado = 1'b1;
      @(negedge clk);
      balance_actualizado = 1'b0;
      wait_done(ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL restart_done_wait: got no done want done"); end
      @(negedge clk);
      tests++;
      if (n_dig - b_dig !== 4 || dig_val[b_dig] !== 4 || dig_val[b_dig + 3] !== 1) begin
         fails++; $display("FAIL restart_digits: got n=%0d first=%0d last=%0d want 4 4 1",
                           n_dig - b_dig, dig_val[b_dig], dig_val[b_dig + 3]);
      end
      tests++;
      if (done_res !== 3'd0 || done_int !== 2'd1 || monto_seen !== 32'd77) begin
         fails++; $display("FAIL restart_result: got res=%0d int=%0d monto=%0d want 0 1 77",
                           done_res, done_int, monto_seen);
      end
   endtask

   initial begin
      test_reset();
      test_deposit();
      test_insufficient();
      test_bad_pin_once();
      test_three_bad();
      test_timeout();
      test_busy_start_and_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
